jtexterm_colmix: RTL and testbench

Colour mixer and palette stage for the Extermination core, directly downstream of the main CPU block. It holds the 1 KB palette RAM written by the main CPU through `pal_cs`/`cpu_wrn`/`cpu_dout`, offers read-back to the CPU, and converts the 9-bit pixel colour index from the Seta sprite/tile generator into 5-5-5 RGB. Blanking signals travel through the same pipeline, so colour and blanking reach the video output aligned.

---
 rtl/jtexterm_colmix_if.sv | 28 ++
 rtl/jtexterm_colmix.sv | 119 +++++++++++
 tb/tb_jtexterm_colmix.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtexterm_colmix_if.sv
// Bus bundle for the colour mixer: CPU palette port plus pixel/blanking video port.
// The master side is the CPU/video generator; the slave side is the mixer.
interface jtexterm_colmix_if;
    logic       pxl_cen;
    logic       pal_cs;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic       cpu_wrn;
    logic [7:0] pal_dout;
    logic [8:0] pxl;
    logic       LHBL;
    logic       LVBL;
    logic [4:0] red;
    logic [4:0] green;
    logic [4:0] blue;
    logic       LHBL_dly;
    logic       LVBL_dly;

    modport master (
        output pxl_cen, pal_cs, cpu_addr, cpu_dout, cpu_wrn, pxl, LHBL, LVBL,
        input  pal_dout, red, green, blue, LHBL_dly, LVBL_dly
    );

    modport slave (
        input  pxl_cen, pal_cs, cpu_addr, cpu_dout, cpu_wrn, pxl, LHBL, LVBL,
        output pal_dout, red, green, blue, LHBL_dly, LVBL_dly
    );
endinterface

// File: rtl/jtexterm_colmix.sv
// Palette RAM (two 512x8 banks, CPU write/read-back) and 2-stage pixel colour lookup
// producing 5-5-5 RGB with blanking carried through the same pipeline.
module jtexterm_colmix #(
    parameter bit BLANK_BLACK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    jtexterm_colmix_if.slave  bus
);
    typedef enum logic {IDLE, HELD} state_t;

    state_t     state_q, state_d;
    logic       armed_q, armed_d;
    logic       wr_req;
    logic       ram_we;

    logic [7:0] ram_hi [0:511];
    logic [7:0] ram_lo [0:511];
    logic [7:0] pix_hi_q, pix_lo_q;
    logic [7:0] cpu_hi_q, cpu_lo_q;

    logic       rd_valid_q, rd_valid_d;
    logic       rd_sel_q, rd_sel_d;
    logic       lhbl1_q, lhbl1_d, lvbl1_q, lvbl1_d;
    logic       lhbl_dly_q, lhbl_dly_d, lvbl_dly_q, lvbl_dly_d;
    logic [4:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

    assign wr_req = bus.pal_cs & ~bus.cpu_wrn;

    // armed_q stays low after reset until the strobe is seen inactive, so a strobe
    // still held across reset release cannot produce a second write.
    always_comb begin
        state_d = state_q;
        ram_we  = 1'b0;
        armed_d = armed_q | ~wr_req;
        case (state_q)
            IDLE: if (wr_req && armed_q) begin
                state_d = HELD;
                ram_we  = 1'b1;
            end
            HELD: if (!wr_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Block RAM: synchronous write, registered reads (read-before-write on collision)
    always_ff @(posedge clk) begin
        if (ram_we && !bus.cpu_addr[0]) ram_hi[bus.cpu_addr[9:1]] <= bus.cpu_dout;
        if (ram_we &&  bus.cpu_addr[0]) ram_lo[bus.cpu_addr[9:1]] <= bus.cpu_dout;
        cpu_hi_q <= ram_hi[bus.cpu_addr[9:1]];
        cpu_lo_q <= ram_lo[bus.cpu_addr[9:1]];
        if (bus.pxl_cen) begin
            pix_hi_q <= ram_hi[bus.pxl];
            pix_lo_q <= ram_lo[bus.pxl];
        end
    end

    always_comb begin
        rd_valid_d = 1'b1;
        rd_sel_d   = bus.cpu_addr[0];
        lhbl1_d    = lhbl1_q;
        lvbl1_d    = lvbl1_q;
        lhbl_dly_d = lhbl_dly_q;
        lvbl_dly_d = lvbl_dly_q;
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        if (bus.pxl_cen) begin
            lhbl1_d    = bus.LHBL;
            lvbl1_d    = bus.LVBL;
            lhbl_dly_d = lhbl1_q;
            lvbl_dly_d = lvbl1_q;
            if (BLANK_BLACK && !(lhbl1_q && lvbl1_q)) begin
                red_d   = 5'd0;
                green_d = 5'd0;
                blue_d  = 5'd0;
            end else begin
                red_d   = pix_hi_q[6:2];
                green_d = {pix_hi_q[1:0], pix_lo_q[7:5]};
                blue_d  = pix_lo_q[4:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            lhbl1_q    <= 1'b0;
            lvbl1_q    <= 1'b0;
            lhbl_dly_q <= 1'b0;
            lvbl_dly_q <= 1'b0;
            red_q      <= 5'd0;
            green_q    <= 5'd0;
            blue_q     <= 5'd0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            rd_valid_q <= rd_valid_d;
            rd_sel_q   <= rd_sel_d;
            lhbl1_q    <= lhbl1_d;
            lvbl1_q    <= lvbl1_d;
            lhbl_dly_q <= lhbl_dly_d;
            lvbl_dly_q <= lvbl_dly_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
        end
    end

    assign bus.pal_dout = !rd_valid_q ? 8'd0 : (rd_sel_q ? cpu_lo_q : cpu_hi_q);
    assign bus.red      = red_q;
    assign bus.green    = green_q;
    assign bus.blue     = blue_q;
    assign bus.LHBL_dly = lhbl_dly_q;
    assign bus.LVBL_dly = lvbl_dly_q;
endmodule

// File: tb/tb_jtexterm_colmix.sv
// Directed bench for jtexterm_colmix: two instances (BLANK_BLACK=1 and 0) share stimulus.
module tb_jtexterm_colmix;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   wr_count = 0;
    int   cen_cnt = 0;

    jtexterm_colmix_if bus0();
    jtexterm_colmix_if bus1();

    jtexterm_colmix #(.BLANK_BLACK(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    jtexterm_colmix #(.BLANK_BLACK(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus1.pxl_cen  = bus0.pxl_cen;
    assign bus1.pal_cs   = bus0.pal_cs;
    assign bus1.cpu_addr = bus0.cpu_addr;
    assign bus1.cpu_dout = bus0.cpu_dout;
    assign bus1.cpu_wrn  = bus0.cpu_wrn;
    assign bus1.pxl      = bus0.pxl;
    assign bus1.LHBL     = bus0.LHBL;
    assign bus1.LVBL     = bus0.LVBL;

    always #5 clk = ~clk;

    // pixel enable: one clk in four
    initial begin
        bus0.pxl_cen = 1'b0;
        forever begin
            @(negedge clk);
            cen_cnt = (cen_cnt + 1) % 4;
            bus0.pxl_cen = (cen_cnt == 3);
        end
    end

    always @(posedge clk) if (dut0.ram_we === 1'b1) wr_count++;

    task automatic wait_cen(input int n);
        repeat (n) begin
            @(posedge clk);
            while (bus0.pxl_cen !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        bus0.pal_cs = 1'b1; bus0.cpu_wrn = 1'b0; bus0.cpu_addr = a; bus0.cpu_dout = d;
        @(negedge clk);
        bus0.pal_cs = 1'b0; bus0.cpu_wrn = 1'b1;
    endtask

    task automatic cpu_read(input logic [9:0] a, output logic [7:0] d);
        @(negedge clk);
        bus0.pal_cs = 1'b1; bus0.cpu_wrn = 1'b1; bus0.cpu_addr = a;
        @(negedge clk);
        d = bus0.pal_dout;
        bus0.pal_cs = 1'b0;
    endtask

    task automatic test_reset;
        bus0.pal_cs = 1'b0; bus0.cpu_wrn = 1'b1; bus0.cpu_addr = '0; bus0.cpu_dout = '0;
        bus0.pxl = '0; bus0.LHBL = 1'b1; bus0.LVBL = 1'b1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        total++;
        if ({bus0.red, bus0.green, bus0.blue} !== 15'd0) begin
            bad++; $display("FAIL reset_rgb0 got=%h exp=0000", {bus0.red, bus0.green, bus0.blue});
        end
        total++;
        if ({bus1.red, bus1.green, bus1.blue} !== 15'd0) begin
            bad++; $display("FAIL reset_rgb1 got=%h exp=0000", {bus1.red, bus1.green, bus1.blue});
        end
        total++;
        if ({bus0.LHBL_dly, bus0.LVBL_dly} !== 2'b00) begin
            bad++; $display("FAIL reset_blank got=%b exp=00", {bus0.LHBL_dly, bus0.LVBL_dly});
        end
        total++;
        if (bus0.pal_dout !== 8'd0) begin
            bad++; $display("FAIL reset_pal_dout got=%h exp=00", bus0.pal_dout);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_latency;
        cpu_write(10'h028, 8'h0C); cpu_write(10'h029, 8'hA7);   // entry 20: R=3 G=5 B=7
        cpu_write(10'h02A, 8'h43); cpu_write(10'h02B, 8'h41);   // entry 21: R=10 G=1A B=01
        bus0.pxl = 9'd21;
        wait_cen(3);
        total++;
        if ({bus0.red, bus0.green, bus0.blue} !== {5'h10, 5'h1A, 5'h01}) begin
            bad++; $display("FAIL lat_steady got=%h exp=%h", {bus0.red, bus0.green, bus0.blue}, {5'h10, 5'h1A, 5'h01});
        end
        bus0.pxl = 9'd20;
        wait_cen(1);
        total++;
        if ({bus0.red, bus0.green, bus0.blue} !== {5'h10, 5'h1A, 5'h01}) begin
            bad++; $display("FAIL lat_one_cen got=%h exp=%h", {bus0.red, bus0.green, bus0.blue}, {5'h10, 5'h1A, 5'h01});
        end
        wait_cen(1);
        total++;
        if ({bus0.red, bus0.green, bus0.blue} !== {5'h03, 5'h05, 5'h07}) begin
            bad++; $display("FAIL lat_two_cen got=%h exp=%h", {bus0.red, bus0.green, bus0.blue}, {5'h03, 5'h05, 5'h07});
        end
        total++;
        if ({bus1.red, bus1.green, bus1.blue} !== {5'h03, 5'h05, 5'h07}) begin
            bad++; $display("FAIL lat_two_cen_nb got=%h exp=%h", {bus1.red, bus1.green, bus1.blue}, {5'h03, 5'h05, 5'h07});
        end
        $display("test_latency done");
    endtask

    task automatic test_unpack;
        cpu_write(10'h002, 8'h7C);
        cpu_write(10'h003, 8'h1F);
        bus0.pxl = 9'd1;
        wait_cen(2);
        total++;
        if ({bus0.red, bus0.green, bus0.blue} !== {5'h1F, 5'h00, 5'h1F}) begin
            bad++; $display("FAIL unpack got=%h exp=%h", {bus0.red, bus0.green, bus0.blue}, {5'h1F, 5'h00, 5'h1F});
        end
        cpu_write(10'h002, 8'hFC);
        wait_cen(2);
        total++;
        if ({bus0.red, bus0.green, bus0.blue} !== {5'h1F, 5'h00, 5'h1F}) begin
            bad++; $display("FAIL unpack_bit15 got=%h exp=%h", {bus0.red, bus0.green, bus0.blue}, {5'h1F, 5'h00, 5'h1F});
        end
        $display("test_unpack done");
    endtask

    task automatic test_single_write;
        int wc0;
        logic [7:0] d;
        wc0 = wr_count;
        @(negedge clk);
        bus0.pal_cs = 1'b1; bus0.cpu_wrn = 1'b0; bus0.cpu_addr = 10'h010; bus0.cpu_dout = 8'h11;
        @(negedge clk);
        bus0.cpu_dout = 8'h22;
        repeat (7) @(negedge clk);
        bus0.pal_cs = 1'b0; bus0.cpu_wrn = 1'b1;
        total++;
        if (wr_count - wc0 != 1) begin
            bad++; $display("FAIL single_write_count got=%0d exp=1", wr_count - wc0);
        end
        cpu_read(10'h010, d);
        total++;
        if (d !== 8'h11) begin
            bad++; $display("FAIL single_write_data got=%h exp=11", d);
        end
        $display("test_single_write done");
    endtask

    task automatic test_readback;
        logic [7:0] d;
        cpu_write(10'h3FF, 8'hA5);
        cpu_write(10'h3FE, 8'h5A);
        cpu_read(10'h3FF, d);
        total++;
        if (d !== 8'hA5) begin
            bad++; $display("FAIL readback_lo got=%h exp=a5", d);
        end
        cpu_read(10'h3FE, d);
        total++;
        if (d !== 8'h5A) begin
            bad++; $display("FAIL readback_hi got=%h exp=5a", d);
        end
        $display("test_readback done");
    endtask

    task automatic test_blanking;
        logic [11:0] hseq;
        logic [11:0] vseq;
        logic        blank_n;
        hseq = 12'b111111000011;   // LHBL low on pixels 2..5
        vseq = 12'b111011111111;   // LVBL low on pixel 8
        cpu_write(10'h00A, 8'h7F);
        cpu_write(10'h00B, 8'hFF);
        bus0.pxl = 9'd5; bus0.LHBL = 1'b1; bus0.LVBL = 1'b1;
        wait_cen(3);
        for (int k = 0; k < 12; k++) begin
            bus0.LHBL = hseq[k];
            bus0.LVBL = vseq[k];
            wait_cen(1);
            if (k >= 1) begin
                blank_n = hseq[k-1] & vseq[k-1];
                total++;
                if ({bus0.LHBL_dly, bus0.LVBL_dly} !== {hseq[k-1], vseq[k-1]}) begin
                    bad++; $display("FAIL blank_dly k=%0d got=%b exp=%b", k, {bus0.LHBL_dly, bus0.LVBL_dly}, {hseq[k-1], vseq[k-1]});
                end
                total++;
                if ({bus0.red, bus0.green, bus0.blue} !== (blank_n ? 15'h7FFF : 15'h0000)) begin
                    bad++; $display("FAIL blank_rgb k=%0d got=%h exp=%h", k, {bus0.red, bus0.green, bus0.blue}, (blank_n ? 15'h7FFF : 15'h0000));
                end
                total++;
                if ({bus1.red, bus1.green, bus1.blue} !== 15'h7FFF) begin
                    bad++; $display("FAIL blank_pass k=%0d got=%h exp=7fff", k, {bus1.red, bus1.green, bus1.blue});
                end
            end
        end
        $display("test_blanking done");
    endtask

    task automatic test_collision;
        cpu_write(10'h012, 8'h04);   // entry 9: R=1
        cpu_write(10'h013, 8'h00);
        bus0.pxl = 9'd9;
        wait_cen(3);
        repeat (3) @(posedge clk);
        #1;
        // next posedge is a pixel-enable edge: write and pixel read coincide
        bus0.pal_cs = 1'b1; bus0.cpu_wrn = 1'b0; bus0.cpu_addr = 10'h012; bus0.cpu_dout = 8'h08;
        @(posedge clk);
        #1;
        bus0.pal_cs = 1'b0; bus0.cpu_wrn = 1'b1;
        wait_cen(1);
        total++;
        if (bus0.red !== 5'h01) begin
            bad++; $display("FAIL collision_old got=%h exp=01", bus0.red);
        end
        wait_cen(1);
        total++;
        if (bus0.red !== 5'h02) begin
            bad++; $display("FAIL collision_new got=%h exp=02", bus0.red);
        end
        $display("test_collision done");
    endtask

    task automatic test_reset_midwrite;
        int wc0;
        logic [7:0] d;
        wc0 = wr_count;
        @(negedge clk);
        bus0.pal_cs = 1'b1; bus0.cpu_wrn = 1'b0; bus0.cpu_addr = 10'h020; bus0.cpu_dout = 8'h33;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus0.cpu_dout = 8'h44;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus0.pal_cs = 1'b0; bus0.cpu_wrn = 1'b1;
        total++;
        if (wr_count - wc0 != 1) begin
            bad++; $display("FAIL midreset_count got=%0d exp=1", wr_count - wc0);
        end
        cpu_read(10'h020, d);
        total++;
        if (d !== 8'h33) begin
            bad++; $display("FAIL midreset_data got=%h exp=33", d);
        end
        $display("test_reset_midwrite done");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_unpack();
        test_single_write();
        test_readback();
        test_blanking();
        test_collision();
        test_reset_midwrite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
